// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Parametrised raster timing generator. Walks a (hc, vc) raster on the pixel
// clock-enable and produces registered counters, blanking, sync, DE, a
// frame-start strobe and a blanked copy of the incoming RGB. All outputs carry
// one ce_pix of latency relative to the internal counters.
//
// A runtime left-column mask and signed H/V sync offsets are latched once per
// frame, on the last pixel of the frame, so changes never tear a frame.
//
// Ports:
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset
//   ce_pix       pixel clock enable; all state advances only when high
//   mask_left    number of leading active columns forced blank
//   hoffset      signed HSync shift in pixels (-8..+7)
//   voffset      signed VSync shift in lines  (-8..+7)
//   rgb_in       pixel colour from the video board
//   rgb_out      blanked, registered pixel colour
//   hcnt, vcnt   raster position aligned with the other outputs
//   hb, vb       horizontal / vertical blank, active high
//   hs, vs       horizontal / vertical sync, active low
//   de           display enable, ~(hb | vb)
//   frame_start  one-clk_sys pulse when position (0,0) is output
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_TOTAL      = 318,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 283,
    parameter int H_SYNC_LEN   = 20,
    parameter int V_TOTAL      = 256,
    parameter int V_ACTIVE     = 240,
    parameter int V_SYNC_START = 251,
    parameter int V_SYNC_LEN   = 3,
    parameter int RGB_W        = 24,
    parameter int MASK_W       = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic [MASK_W-1:0] mask_left,
    input  logic [3:0]        hoffset,
    input  logic [3:0]        voffset,
    input  logic [RGB_W-1:0]  rgb_in,
    output logic [RGB_W-1:0]  rgb_out,
    output logic [8:0]        hcnt,
    output logic [8:0]        vcnt,
    output logic              hb,
    output logic              vb,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic              frame_start
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);

    // Sync arithmetic runs in 11-bit signed so offset sums never wrap silently.
    localparam logic signed [10:0] H_TOT_S = 11'(H_TOTAL);
    localparam logic signed [10:0] H_SS_S  = 11'(H_SYNC_START);
    localparam logic signed [10:0] H_SL_S  = 11'(H_SYNC_LEN);
    localparam logic signed [10:0] V_TOT_S = 11'(V_TOTAL);
    localparam logic signed [10:0] V_SS_S  = 11'(V_SYNC_START);
    localparam logic signed [10:0] V_SL_S  = 11'(V_SYNC_LEN);

    // Mask compare width wide enough for both the mask and the column counter.
    localparam int CW = (MASK_W > 9) ? MASK_W : 9;

    logic [8:0]        hc_r;
    logic [8:0]        vc_r;
    logic [MASK_W-1:0] mask_l_r;
    logic [3:0]        hoff_l_r;
    logic [3:0]        voff_l_r;

    logic [8:0]        hc_nxt_s;
    logic [8:0]        vc_nxt_s;
    logic              latch_s;
    logic              hb_s;
    logic              vb_s;
    logic              hs_s;
    logic              vs_s;
    logic              blank_s;
    logic              fs_s;
    logic [RGB_W-1:0]  rgb_s;

    // True when pos lies in the sync window [start+off, start+off+len) taken
    // modulo total. The start is folded back into range first, then the
    // distance from the start is folded so windows that straddle the raster
    // wrap are handled.
    function automatic logic sync_active(
        input logic [8:0]         pos,
        input logic [3:0]         off,
        input logic signed [10:0] start,
        input logic signed [10:0] total,
        input logic signed [10:0] len
    );
        logic signed [10:0] s0_v;
        logic signed [10:0] d_v;
        s0_v = start + $signed({{7{off[3]}}, off});
        if (s0_v < 11'sd0) begin
            s0_v = s0_v + total;
        end else if (s0_v >= total) begin
            s0_v = s0_v - total;
        end else begin
            s0_v = s0_v;
        end
        d_v = $signed({2'b00, pos}) - s0_v;
        if (d_v < 11'sd0) begin
            d_v = d_v + total;
        end else begin
            d_v = d_v;
        end
        return (d_v < len);
    endfunction

    // Next raster position, frame-end latch strobe and decodes of the current position.
    always_comb begin
        hc_nxt_s = hc_r + 9'd1;
        vc_nxt_s = vc_r;
        if (hc_r == H_LAST) begin
            hc_nxt_s = 9'd0;
            if (vc_r == V_LAST) begin
                vc_nxt_s = 9'd0;
            end else begin
                vc_nxt_s = vc_r + 9'd1;
            end
        end else begin
            vc_nxt_s = vc_r;
        end

        latch_s = (hc_r == H_LAST) && (vc_r == V_LAST);
        hb_s    = (CW'(hc_r) < CW'(mask_l_r)) || (hc_r >= H_ACT);
        vb_s    = (vc_r >= V_ACT);
        hs_s    = ~sync_active(hc_r, hoff_l_r, H_SS_S, H_TOT_S, H_SL_S);
        vs_s    = ~sync_active(vc_r, voff_l_r, V_SS_S, V_TOT_S, V_SL_S);
        blank_s = hb_s | vb_s;
        fs_s    = (hc_r == 9'd0) && (vc_r == 9'd0);
        rgb_s   = blank_s ? {RGB_W{1'b0}} : rgb_in;
    end

    // Raster counters and once-per-frame latching of mask and sync offsets.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hc_r     <= 9'd0;
            vc_r     <= 9'd0;
            mask_l_r <= {MASK_W{1'b0}};
            hoff_l_r <= 4'd0;
            voff_l_r <= 4'd0;
        end else if (ce_pix) begin
            hc_r <= hc_nxt_s;
            vc_r <= vc_nxt_s;
            if (latch_s) begin
                mask_l_r <= mask_left;
                hoff_l_r <= hoffset;
                voff_l_r <= voffset;
            end
        end
    end

    // Output stage: registered decodes of the pre-increment position.
    // frame_start is a strobe, so it drops on any cycle without ce_pix.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hcnt        <= 9'd0;
            vcnt        <= 9'd0;
            hb          <= 1'b1;
            vb          <= 1'b1;
            hs          <= 1'b1;
            vs          <= 1'b1;
            de          <= 1'b0;
            rgb_out     <= {RGB_W{1'b0}};
            frame_start <= 1'b0;
        end else if (ce_pix) begin
            hcnt        <= hc_r;
            vcnt        <= vc_r;
            hb          <= hb_s;
            vb          <= vb_s;
            hs          <= hs_s;
            vs          <= vs_s;
            de          <= ~blank_s;
            rgb_out     <= rgb_s;
            frame_start <= fs_s;
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule
